// File: rtl/pll_lock_supervisor.sv
// Reset/lock sequencer for a PLL: pulses the PLL reset, waits for qualified lock with timeout and
// bounded retries, and releases the downstream system reset only after lock has been stable.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 36,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 360000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int unsigned PulseW  = $clog2(RST_PULSE_CYCLES + 1);
  localparam int unsigned StableW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [PulseW-1:0]  PulseLast   = PulseW'(RST_PULSE_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast  = StableW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         RetryMax    = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StResetPll  = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StRun       = 3'd3,
    StFault     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [PulseW-1:0]   pulse_q, pulse_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [StableW-1:0]  stable_q, stable_d;
  logic [1:0]          retry_q, retry_d;
  logic [7:0]          loss_q, loss_d;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_q, sys_rst_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;

  logic   locked;
  logic   timeout;
  state_e timeout_state;
  logic   timeout_fatal;

  assign locked        = sync_q[1];
  assign timeout       = (timer_q == TimeoutLast);
  assign timeout_fatal = (retry_q == RetryMax);
  assign timeout_state = timeout_fatal ? StFault : StResetPll;

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[0], pll_locked};
    pulse_d  = pulse_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    loss_d   = loss_q;

    // Lock loss in RUN wins over a coincident relock so the loss is always counted.
    if (state_q == StRun && !locked) begin
      loss_d   = (loss_q == 8'hff) ? loss_q : loss_q + 8'd1;
      retry_d  = '0;
      state_d  = StResetPll;
      pulse_d  = '0;
      timer_d  = '0;
      stable_d = '0;
    end else if (relock_req) begin
      state_d  = StResetPll;
      retry_d  = '0;
      pulse_d  = '0;
      timer_d  = '0;
      stable_d = '0;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (pulse_q == PulseLast) begin
            state_d  = StWaitLock;
            timer_d  = '0;
            stable_d = '0;
          end else begin
            pulse_d = pulse_q + PulseW'(1);
          end
        end
        StWaitLock: begin
          timer_d = timer_q + CNT_W'(1);
          if (locked) begin
            state_d  = StStabilize;
            stable_d = '0;
          end else if (timeout) begin
            state_d = timeout_state;
            pulse_d = '0;
            if (!timeout_fatal) retry_d = retry_q + 2'd1;
          end
        end
        StStabilize: begin
          // The timer keeps running across lock glitches; only the stable count restarts.
          timer_d = timer_q + CNT_W'(1);
          if (!locked) begin
            state_d  = StWaitLock;
            stable_d = '0;
          end else if (stable_q == StableLast) begin
            state_d = StRun;
          end else if (timeout) begin
            state_d = timeout_state;
            pulse_d = '0;
            if (!timeout_fatal) retry_d = retry_q + 2'd1;
          end else begin
            stable_d = stable_q + StableW'(1);
          end
        end
        StRun:   ;
        StFault: ;
        default: state_d = StResetPll;
      endcase
    end

    pll_rst_d = (state_d == StResetPll) || (state_d == StFault);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
    fault_d   = (state_d == StFault);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StResetPll;
      sync_q    <= '0;
      pulse_q   <= '0;
      timer_q   <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      pulse_q   <= pulse_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule
